// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and constants for the Wishbone round-robin arbiter and its users.
// Cycle-type / burst-type encodings are carried for masters and benches; the arbiter does not decode them.
package wb_rr_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC      = 3'b000;
    localparam logic [2:0] CTI_CONST_BURST  = 3'b001;
    localparam logic [2:0] CTI_INC_BURST    = 3'b010;
    localparam logic [2:0] CTI_END_OF_BURST = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP_4  = 2'b01;
    localparam logic [1:0] BTE_WRAP_8  = 2'b10;
    localparam logic [1:0] BTE_WRAP_16 = 2'b11;

    // Width of a master index; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of the bus watchdog counter; a disabled watchdog still gets one bit.
    function automatic int wdog_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of the master-side and slave-side Wishbone signals around the arbiter.
// Master k occupies slice [k*W +: W] of every packed master-side vector.
interface wb_rr_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 32,
    parameter int DW          = 32
);
    logic [NUM_MASTERS*AW-1:0]     wbm_adr_i;
    logic [NUM_MASTERS*DW-1:0]     wbm_dat_i;
    logic [NUM_MASTERS*DW/8-1:0]   wbm_sel_i;
    logic [NUM_MASTERS-1:0]        wbm_we_i;
    logic [NUM_MASTERS-1:0]        wbm_cyc_i;
    logic [NUM_MASTERS-1:0]        wbm_stb_i;
    logic [NUM_MASTERS*3-1:0]      wbm_cti_i;
    logic [NUM_MASTERS*2-1:0]      wbm_bte_i;
    logic [DW-1:0]                 wbm_dat_o;
    logic [NUM_MASTERS-1:0]        wbm_ack_o;
    logic [NUM_MASTERS-1:0]        wbm_err_o;

    logic [AW-1:0]                 wbs_adr_o;
    logic [DW-1:0]                 wbs_dat_o;
    logic [DW/8-1:0]               wbs_sel_o;
    logic                          wbs_we_o;
    logic                          wbs_cyc_o;
    logic                          wbs_stb_o;
    logic [2:0]                    wbs_cti_o;
    logic [1:0]                    wbs_bte_o;
    logic [DW-1:0]                 wbs_dat_i;
    logic                          wbs_ack_i;
    logic                          wbs_err_i;

    logic [NUM_MASTERS-1:0]        grant_o;

    modport arbiter (
        input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
        output wbm_dat_o, wbm_ack_o, wbm_err_o,
        output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
        input  wbs_dat_i, wbs_ack_i, wbs_err_i,
        output grant_o
    );

    modport master (
        output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
        input  wbm_dat_o, wbm_ack_o, wbm_err_o, grant_o
    );

    modport slave (
        input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
        output wbs_dat_i, wbs_ack_i, wbs_err_i
    );

endinterface

// File: rtl/wb_rr_pick.sv
// Combinational round-robin priority encoder: first requester scanning upward from last+1.
// Shared with the SDRAM port scheduler, so it carries no bus-specific logic.
module wb_rr_pick
    import wb_rr_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IW          = idx_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IW-1:0]          last,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [IW-1:0]          gnt_idx,
    output logic                   valid
);
    logic [2*NUM_MASTERS-1:0] dbl_s;
    logic [NUM_MASTERS-1:0]   rot_s;
    logic [IW:0]              shift_s;
    logic                     found_s;
    int                       pos_s;

    // Rotate the request vector so bit 0 is master (last+1) mod N, then take the lowest set bit.
    always_comb begin
        shift_s = {1'b0, last} + {{IW{1'b0}}, 1'b1};
        dbl_s   = {req, req} >> shift_s;
        rot_s   = dbl_s[NUM_MASTERS-1:0];
        found_s = 1'b0;
        pos_s   = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found_s && rot_s[i]) begin
                found_s = 1'b1;
                pos_s   = (int'(last) + 1 + i) % NUM_MASTERS;
            end else begin
                found_s = found_s;
            end
        end
        gnt     = found_s ? ({{(NUM_MASTERS-1){1'b0}}, 1'b1} << pos_s) : {NUM_MASTERS{1'b0}};
        gnt_idx = IW'(pos_s);
        valid   = found_s;
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: one slave port shared by NUM_MASTERS masters, grant held per cyc,
// with a bus watchdog that errors an access the slave never answers.
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    wb_rr_arbiter_if.arbiter bus
);
    localparam int IW = idx_width(NUM_MASTERS);
    localparam int CW = wdog_width(TIMEOUT);
    localparam int SW = DW / 8;
    localparam logic [CW-1:0] WDOG_LIMIT = CW'(TIMEOUT);

    arb_state_e             state_r, state_nx_s;
    logic [NUM_MASTERS-1:0] grant_r, grant_nx_s;
    logic [IW-1:0]          owner_r, owner_nx_s;
    logic [IW-1:0]          last_r, last_nx_s;
    logic [CW-1:0]          wdog_r, wdog_nx_s;

    logic [IW-1:0]          pick_last_s, pick_idx_s;
    logic [NUM_MASTERS-1:0] pick_gnt_s;
    logic                   pick_valid_s;

    logic [AW-1:0]          adr_s;
    logic [DW-1:0]          dat_s;
    logic [SW-1:0]          sel_s;
    logic [2:0]             cti_s;
    logic [1:0]             bte_s;
    logic                   we_s, owner_cyc_s, owner_stb_s;
    logic                   timeout_s, stb_out_s, resp_ok_s;

    // When the owner is releasing, the scan starts after the owner so the hand-off is fair on the same edge.
    assign pick_last_s = (state_r == ST_OWN) ? owner_r : last_r;

    wb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IW          (IW)
    ) u_pick (
        .req     (bus.wbm_cyc_i),
        .last    (pick_last_s),
        .gnt     (pick_gnt_s),
        .gnt_idx (pick_idx_s),
        .valid   (pick_valid_s)
    );

    // AND-OR mux of the owner's request; grant_r is zero when idle, so every field idles at 0.
    always_comb begin
        adr_s       = '0;
        dat_s       = '0;
        sel_s       = '0;
        cti_s       = 3'b000;
        bte_s       = 2'b00;
        we_s        = 1'b0;
        owner_cyc_s = 1'b0;
        owner_stb_s = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            adr_s       = adr_s | (bus.wbm_adr_i[k*AW +: AW] & {AW{grant_r[k]}});
            dat_s       = dat_s | (bus.wbm_dat_i[k*DW +: DW] & {DW{grant_r[k]}});
            sel_s       = sel_s | (bus.wbm_sel_i[k*SW +: SW] & {SW{grant_r[k]}});
            cti_s       = cti_s | (bus.wbm_cti_i[k*3 +: 3] & {3{grant_r[k]}});
            bte_s       = bte_s | (bus.wbm_bte_i[k*2 +: 2] & {2{grant_r[k]}});
            we_s        = we_s | (bus.wbm_we_i[k] & grant_r[k]);
            owner_cyc_s = owner_cyc_s | (bus.wbm_cyc_i[k] & grant_r[k]);
            owner_stb_s = owner_stb_s | (bus.wbm_stb_i[k] & grant_r[k]);
        end
    end

    assign timeout_s = (TIMEOUT > 0) && (state_r == ST_OWN) && owner_cyc_s && owner_stb_s
                       && (wdog_r == WDOG_LIMIT);
    // The watchdog cycle withdraws stb so a late slave ack cannot complete the aborted access.
    assign stb_out_s = owner_stb_s & ~timeout_s;
    assign resp_ok_s = owner_cyc_s & stb_out_s;

    assign bus.wbs_adr_o = adr_s;
    assign bus.wbs_dat_o = dat_s;
    assign bus.wbs_sel_o = sel_s;
    assign bus.wbs_cti_o = cti_s;
    assign bus.wbs_bte_o = bte_s;
    assign bus.wbs_we_o  = we_s;
    assign bus.wbs_cyc_o = owner_cyc_s;
    assign bus.wbs_stb_o = stb_out_s;
    assign bus.wbm_dat_o = bus.wbs_dat_i;
    assign bus.wbm_ack_o = grant_r & {NUM_MASTERS{bus.wbs_ack_i & resp_ok_s}};
    assign bus.wbm_err_o = grant_r & {NUM_MASTERS{(bus.wbs_err_i & resp_ok_s) | timeout_s}};
    assign bus.grant_o   = grant_r;

    // Ownership next-state: hold while the owner keeps cyc, hand over or idle when it drops.
    always_comb begin
        state_nx_s = state_r;
        grant_nx_s = grant_r;
        owner_nx_s = owner_r;
        last_nx_s  = last_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_nx_s = ST_OWN;
                    grant_nx_s = pick_gnt_s;
                    owner_nx_s = pick_idx_s;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (owner_cyc_s) begin
                    state_nx_s = ST_OWN;
                end else begin
                    last_nx_s = owner_r;
                    if (pick_valid_s) begin
                        grant_nx_s = pick_gnt_s;
                        owner_nx_s = pick_idx_s;
                    end else begin
                        state_nx_s = ST_IDLE;
                        grant_nx_s = '0;
                    end
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                grant_nx_s = '0;
            end
        endcase
    end

    // Watchdog counts unanswered strobe cycles; any response, idle strobe, release or expiry clears it.
    always_comb begin
        if ((TIMEOUT > 0) && (state_r == ST_OWN) && owner_cyc_s && owner_stb_s
            && !bus.wbs_ack_i && !bus.wbs_err_i && !timeout_s) begin
            wdog_nx_s = wdog_r + CW'(1);
        end else begin
            wdog_nx_s = '0;
        end
    end

    // State registers; the last-owner pointer resets to the top index so master 0 wins first.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r <= ST_IDLE;
            grant_r <= '0;
            owner_r <= '0;
            last_r  <= IW'(NUM_MASTERS - 1);
            wdog_r  <= '0;
        end else begin
            state_r <= state_nx_s;
            grant_r <= grant_nx_s;
            owner_r <= owner_nx_s;
            last_r  <= last_nx_s;
            wdog_r  <= wdog_nx_s;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: two masters, watchdog of 8 cycles, hand-computed expectations.
module tb_wb_rr_arbiter;
    import wb_rr_arbiter_pkg::*;

    logic wb_clk_i;
    logic wb_rst_i;
    int   checks;
    int   failures;

    wb_rr_arbiter_if #(.NUM_MASTERS(2), .AW(32), .DW(32)) bus ();

    wb_rr_arbiter #(
        .NUM_MASTERS (2),
        .AW          (32),
        .DW          (32),
        .TIMEOUT     (8)
    ) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (bus)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
        bus.wbm_cyc_i[k]          = cyc;
        bus.wbm_stb_i[k]          = stb;
        bus.wbm_we_i[k]           = we;
        bus.wbm_adr_i[k*32 +: 32] = adr;
        bus.wbm_dat_i[k*32 +: 32] = dat;
        bus.wbm_sel_i[k*4 +: 4]   = 4'hF;
        bus.wbm_cti_i[k*3 +: 3]   = cti;
        bus.wbm_bte_i[k*2 +: 2]   = BTE_LINEAR;
    endtask

    // Three acked beats for one owner, then release; other master keeps requesting throughout.
    task automatic round(input int owner, input bit rearm);
        logic [1:0]  exp_g;
        logic [31:0] exp_adr;
        exp_g   = 2'b01 << owner;
        exp_adr = (owner == 1) ? 32'h0000_0200 : 32'h0000_0100;
        for (int b = 0; b < 3; b++) begin
            settle();
            chk("t2_grant", 64'(bus.grant_o), 64'(exp_g));
            chk("t2_ack", 64'(bus.wbm_ack_o), 64'(exp_g));
            chk("t2_adr", 64'(bus.wbs_adr_o), 64'(exp_adr));
            tick();
        end
        set_m(owner, 1'b0, 1'b0, 1'b0, exp_adr, 32'h0, CTI_CLASSIC);
        settle();
        chk("t2_drop_cyc", 64'(bus.wbs_cyc_o), 64'h0);
        chk("t2_drop_grant", 64'(bus.grant_o), 64'(exp_g));
        tick();
        if (rearm) set_m(owner, 1'b1, 1'b1, 1'b0, exp_adr, 32'h0, CTI_CLASSIC);
    endtask

    initial begin
        #200000;
        $display("FAIL tb_watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        failures = 0;
        wb_rst_i = 1'b1;
        bus.wbm_adr_i = '0;
        bus.wbm_dat_i = '0;
        bus.wbm_sel_i = '0;
        bus.wbm_we_i  = '0;
        bus.wbm_cyc_i = '0;
        bus.wbm_stb_i = '0;
        bus.wbm_cti_i = '0;
        bus.wbm_bte_i = '0;
        bus.wbs_dat_i = 32'h0;
        bus.wbs_ack_i = 1'b0;
        bus.wbs_err_i = 1'b0;

        // Reset state
        tick();
        tick();
        settle();
        chk("rst_grant", 64'(bus.grant_o), 64'h0);
        chk("rst_cyc", 64'(bus.wbs_cyc_o), 64'h0);
        chk("rst_stb", 64'(bus.wbs_stb_o), 64'h0);
        chk("rst_ack", 64'(bus.wbm_ack_o), 64'h0);
        chk("rst_err", 64'(bus.wbm_err_o), 64'h0);
        chk("rst_adr", 64'(bus.wbs_adr_o), 64'h0);
        wb_rst_i = 1'b0;
        tick();

        // Single master write, 1-cycle arbitration latency, ack on the 2nd slave cycle
        set_m(0, 1'b1, 1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, CTI_CLASSIC);
        settle();
        chk("t1_lat_cyc", 64'(bus.wbs_cyc_o), 64'h0);
        chk("t1_lat_grant", 64'(bus.grant_o), 64'h0);
        tick();
        settle();
        chk("t1_grant", 64'(bus.grant_o), 64'h1);
        chk("t1_cyc", 64'(bus.wbs_cyc_o), 64'h1);
        chk("t1_adr", 64'(bus.wbs_adr_o), 64'h1000);
        chk("t1_dat", 64'(bus.wbs_dat_o), 64'hDEAD_BEEF);
        chk("t1_we", 64'(bus.wbs_we_o), 64'h1);
        chk("t1_sel", 64'(bus.wbs_sel_o), 64'hF);
        chk("t1_noack", 64'(bus.wbm_ack_o), 64'h0);
        tick();
        bus.wbs_ack_i = 1'b1;
        settle();
        chk("t1_ack", 64'(bus.wbm_ack_o), 64'h1);
        tick();
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
        bus.wbs_ack_i = 1'b0;
        settle();
        chk("t1_ack_clear", 64'(bus.wbm_ack_o), 64'h0);
        chk("t1_cyc_drop", 64'(bus.wbs_cyc_o), 64'h0);
        tick();
        settle();
        chk("t1_idle", 64'(bus.grant_o), 64'h0);

        // Contention: last owner was m0, so m1 wins first, then strict alternation
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, CTI_CLASSIC);
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, CTI_CLASSIC);
        bus.wbs_ack_i = 1'b1;
        tick();
        round(1, 1'b1);
        round(0, 1'b1);
        round(1, 1'b1);
        round(0, 1'b0);
        bus.wbs_ack_i = 1'b0;
        settle();
        chk("t2_final_handoff", 64'(bus.grant_o), 64'h2);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
        tick();
        settle();
        chk("t2_idle", 64'(bus.grant_o), 64'h0);

        // Burst hold: m1 incrementing burst, m0 requests mid-burst and waits
        set_m(1, 1'b1, 1'b1, 1'b1, 32'h0000_2000, 32'h11, CTI_INC_BURST);
        bus.wbs_ack_i = 1'b1;
        tick();
        settle();
        chk("t3_b1_grant", 64'(bus.grant_o), 64'h2);
        chk("t3_b1_cti", 64'(bus.wbs_cti_o), 64'(CTI_INC_BURST));
        chk("t3_b1_ack", 64'(bus.wbm_ack_o), 64'h2);
        tick();
        set_m(1, 1'b1, 1'b1, 1'b1, 32'h0000_2004, 32'h22, CTI_INC_BURST);
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_3000, 32'h0, CTI_CLASSIC);
        settle();
        chk("t3_b2_grant", 64'(bus.grant_o), 64'h2);
        chk("t3_b2_adr", 64'(bus.wbs_adr_o), 64'h2004);
        chk("t3_b2_ack", 64'(bus.wbm_ack_o), 64'h2);
        tick();
        set_m(1, 1'b1, 1'b1, 1'b1, 32'h0000_2008, 32'h33, CTI_INC_BURST);
        settle();
        chk("t3_b3_grant", 64'(bus.grant_o), 64'h2);
        chk("t3_b3_ack", 64'(bus.wbm_ack_o), 64'h2);
        tick();
        set_m(1, 1'b1, 1'b1, 1'b1, 32'h0000_200C, 32'h44, CTI_END_OF_BURST);
        settle();
        chk("t3_b4_grant", 64'(bus.grant_o), 64'h2);
        chk("t3_b4_cti", 64'(bus.wbs_cti_o), 64'(CTI_END_OF_BURST));
        tick();
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
        settle();
        chk("t3_drop_grant", 64'(bus.grant_o), 64'h2);
        chk("t3_drop_cyc", 64'(bus.wbs_cyc_o), 64'h0);
        chk("t3_drop_ack", 64'(bus.wbm_ack_o), 64'h0);
        tick();
        settle();
        chk("t3_handoff_grant", 64'(bus.grant_o), 64'h1);
        chk("t3_handoff_adr", 64'(bus.wbs_adr_o), 64'h3000);
        chk("t3_handoff_cyc", 64'(bus.wbs_cyc_o), 64'h1);
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
        bus.wbs_ack_i = 1'b0;
        tick();
        settle();
        chk("t3_idle", 64'(bus.grant_o), 64'h0);

        // Watchdog: slave never answers; err on slave cycle 9 with stb withdrawn, grant kept
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_4000, 32'h0, CTI_CLASSIC);
        tick();
        for (int c = 1; c <= 10; c++) begin
            settle();
            chk("t4_err", 64'(bus.wbm_err_o), (c == 9) ? 64'h1 : 64'h0);
            chk("t4_stb", 64'(bus.wbs_stb_o), (c == 9) ? 64'h0 : 64'h1);
            chk("t4_grant", 64'(bus.grant_o), 64'h1);
            tick();
        end
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
        tick();
        settle();
        chk("t4_idle", 64'(bus.grant_o), 64'h0);

        // Reset while m1 owns with stb high; afterwards m0 wins the tie
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_5000, 32'h0, CTI_CLASSIC);
        tick();
        settle();
        chk("t5_own_grant", 64'(bus.grant_o), 64'h2);
        chk("t5_own_cyc", 64'(bus.wbs_cyc_o), 64'h1);
        wb_rst_i = 1'b1;
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_6000, 32'h0, CTI_CLASSIC);
        tick();
        settle();
        chk("t5_rst_grant", 64'(bus.grant_o), 64'h0);
        chk("t5_rst_cyc", 64'(bus.wbs_cyc_o), 64'h0);
        chk("t5_rst_stb", 64'(bus.wbs_stb_o), 64'h0);
        chk("t5_rst_ack", 64'(bus.wbm_ack_o), 64'h0);
        tick();
        wb_rst_i = 1'b0;
        tick();
        settle();
        chk("t5_m0_wins", 64'(bus.grant_o), 64'h1);

        // Isolation: m1 takes over; responses reach only the owner, read data is broadcast
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
        tick();
        settle();
        chk("t6_grant", 64'(bus.grant_o), 64'h2);
        bus.wbs_ack_i = 1'b1;
        bus.wbs_dat_i = 32'hCAFE_F00D;
        settle();
        chk("t6_ack_owner_only", 64'(bus.wbm_ack_o), 64'h2);
        chk("t6_dat_bcast", 64'(bus.wbm_dat_o), 64'hCAFE_F00D);
        bus.wbs_err_i = 1'b1;
        settle();
        chk("t6_both_ack", 64'(bus.wbm_ack_o), 64'h2);
        chk("t6_both_err", 64'(bus.wbm_err_o), 64'h2);
        bus.wbs_err_i = 1'b0;
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h0000_5000, 32'h0, CTI_CLASSIC);
        settle();
        chk("t6_ack_stb_low", 64'(bus.wbm_ack_o), 64'h0);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
        bus.wbs_ack_i = 1'b0;
        tick();
        tick();
        bus.wbs_dat_i = 32'h1234_5678;
        settle();
        chk("t6_idle", 64'(bus.grant_o), 64'h0);
        chk("t6_dat_idle", 64'(bus.wbm_dat_o), 64'h1234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin Wishbone B3 arbiter that shares one slave port between NUM_MASTERS masters.
- Typical uses: feeding both nanorv32 and a DMA or debug master into the SoC intercon, or sharing a single SDRAM controller port.
- Grant is held for a whole cycle (cyc) so bursts are never split.
- A bus-watchdog returns err to a master whose slave never acks.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
AW, 32, address width
DW, 32, data width; sel width is DW/8
TIMEOUT, 255, cycles of unacked stb before err is returned; 0 disables the watchdog

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
wbm_adr_i  in  NUM_MASTERS*AW  master addresses, master k at [k*AW +: AW]
wbm_dat_i  in  NUM_MASTERS*DW  master write data
wbm_sel_i  in  NUM_MASTERS*DW/8  byte selects
wbm_we_i  in  NUM_MASTERS  write enables
wbm_cyc_i  in  NUM_MASTERS  cycle requests
wbm_stb_i  in  NUM_MASTERS  strobes
wbm_cti_i  in  NUM_MASTERS*3  cycle type
wbm_bte_i  in  NUM_MASTERS*2  burst type
wbm_dat_o  out  DW  read data, broadcast to all masters
wbm_ack_o  out  NUM_MASTERS  ack, owner only
wbm_err_o  out  NUM_MASTERS  err, owner only
wbs_adr_o / wbs_dat_o / wbs_sel_o / wbs_we_o / wbs_cyc_o / wbs_stb_o / wbs_cti_o / wbs_bte_o  out  AW / DW / DW/8 / 1 / 1 / 1 / 3 / 2  slave side, muxed from owner
wbs_dat_i / wbs_ack_i / wbs_err_i  in  DW / 1 / 1  slave responses
grant_o  out  NUM_MASTERS  one-hot current owner; 0 when idle

Behaviour:
- Reset: grant_o=0; all wbs_* outputs=0; wbm_ack_o=0; wbm_err_o=0; watchdog count=0; last-owner pointer=NUM_MASTERS-1, so master 0 wins the first arbitration.
- States:
  - IDLE: no owner.
  - OWN: grant_o one-hot.
- IDLE -> OWN:
  - When any wbm_cyc_i is high, grant the first requester scanning upward from (last+1) mod NUM_MASTERS.
  - The grant is registered; the slave sees cyc/stb one cycle after the master raises cyc (1-cycle arbitration latency).
- OWN, owner cyc high: hold the grant. Requests from other masters are ignored, even across cti bursts and cyc-held idle gaps.
- OWN, owner cyc low: on the same edge, update last=owner.
  - If any other cyc is high, grant the next requester directly (back-to-back, no IDLE cycle).
  - Otherwise go to IDLE.
- Routing while in OWN:
  - wbs_* outputs are combinationally driven from the owner.
  - wbs_cyc_o = owner cyc; wbs_stb_o = owner stb.
  - wbm_ack_o[owner] = wbs_ack_i and wbm_err_o[owner] = wbs_err_i, both gated by wbs_cyc_o.
  - Non-owner ack/err are always 0.
  - wbm_dat_o = wbs_dat_i unconditionally.
- In IDLE: wbs_cyc_o, wbs_stb_o and wbs_we_o are 0; adr/dat/sel/cti/bte are 0.
- Watchdog (TIMEOUT>0):
  - Counter width clog2(TIMEOUT+1).
  - Increments each cycle the owner stb is high and wbs_ack_i and wbs_err_i are both low; clears on ack, err, stb low or grant change.
  - When count==TIMEOUT: pulse wbm_err_o[owner] for 1 cycle, force wbs_stb_o=0 that cycle, clear the counter. Grant is kept until the owner drops cyc.
- Simultaneous ack and err from the slave: forward both unchanged; the master handles precedence.
- Slave ack while owner stb is low: ignored (gated to 0).
- Reset mid-transfer: all outputs go to reset values at the next edge; no ack is generated for the in-flight access.
- Only one owner can exist at any time, so slave-side accesses from two masters never overlap.

Decomposition:
- Shared include wb_common_params.v: CTI_CLASSIC/CTI_CONST_BURST/CTI_INC_BURST/CTI_END_OF_BURST and BTE_LINEAR/BTE_WRAP_4/8/16 constants. The arbiter does not decode them; they are used by the bench.
- Sub-module wb_rr_pick: combinational round-robin priority encoder.
  - Inputs: req[NUM_MASTERS], last index.
  - Outputs: one-hot next grant and a valid bit.
  - Reusable by the SDRAM port scheduler.

Test Plan:
- Single master: m0 cyc/stb write 0x1000=0xDEADBEEF; slave acks on the 2nd cycle -> wbs_cyc_o high 1 cycle after m0 cyc, wbm_ack_o=01, grant_o=01, then 00 after cyc drops.
- Contention: m0 and m1 raise cyc on the same cycle, each holding for 3 transfers, repeated -> grants alternate 01,10,01,10; m1 is never granted while m0 cyc is high.
- Burst hold: m1 does a 4-beat incrementing burst (cti 010…111) while m0 requests mid-burst -> all 4 beats go to m1; m0 is granted on the edge m1 drops cyc, with no IDLE cycle.
- Timeout (TIMEOUT=8): m0 stb held with the slave never acking -> wbm_err_o[0] pulses exactly on cycle 9 after stb, wbs_stb_o is low that cycle, and the grant is retained.
- Reset mid-transfer: wb_rst_i asserted while m1 owns with stb high -> next cycle grant_o=0, wbs_cyc_o=0; after release with both requesting, m0 wins.
- Isolation: the slave asserts ack while m1 is the owner -> wbm_ack_o[0] stays 0; wbm_dat_o equals wbs_dat_i at all times.
